// File: rtl/bd_pkg.sv
// Shared types and constants for the bundled-data receive path.
package bd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } bd_rx_state_t;

  localparam int BD_MIN_SYNC = 2;

endpackage

// File: rtl/bd_req_sync.sv
// Flop-chain synchronizer that brings the asynchronous BD request into clk.
module bd_req_sync
  import bd_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  // Depth below the metastability floor is silently raised to the minimum.
  localparam int N = (STAGES < BD_MIN_SYNC) ? BD_MIN_SYNC : STAGES;

  logic [N-1:0] r_chain;

  // Shift the raw request through the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= {N{1'b0}};
    end else begin
      r_chain <= {r_chain[N-2:0], i_async};
    end
  end

  assign o_sync = r_chain[N-1];

endmodule

// File: rtl/bd_sync_receiver.sv
// Clocked receiver for a 4-phase bundled-data channel: synchronizes breq,
// captures bdata into a small FIFO and presents it as a valid/ready stream.
module bd_sync_receiver
  import bd_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     breq,
  output logic                     back,
  input  logic [WIDTH-1:0]         bdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic              w_req_s;
  bd_rx_state_t      r_state;
  bd_rx_state_t      w_state_nxt;
  logic              r_back;
  logic              w_back_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW-1:0]     w_rptr_nxt;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [WIDTH-1:0]  w_head_nxt;

  bd_req_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (breq),
    .o_sync  (w_req_s)
  );

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = r_out_valid & out_ready;

  // Handshake next-state: capture once per request, then wait for return-to-zero.
  always_comb begin
    w_state_nxt = r_state;
    w_back_nxt  = r_back;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_s && !w_full) begin
          w_push      = 1'b1;
          w_back_nxt  = 1'b1;
          w_state_nxt = ACKED;
        end else begin
          w_back_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      ACKED: begin
        if (!w_req_s) begin
          w_back_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_back_nxt  = 1'b1;
          w_state_nxt = ACKED;
        end
      end
      default: begin
        w_back_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Handshake state and acknowledge register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_back  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_back  <= w_back_nxt;
    end
  end

  // Next read pointer, occupancy and the head value to present after this edge.
  always_comb begin
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    w_head_nxt  = r_out_data;
    if (w_pop) begin
      w_rptr_nxt = r_rptr + PW'(1);
    end else begin
      w_rptr_nxt = r_rptr;
    end
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    // A new head that is being written this edge must bypass the array.
    if (w_count_nxt == {CW{1'b0}}) begin
      w_head_nxt = r_out_data;
    end else if (w_push && (r_wptr == w_rptr_nxt)) begin
      w_head_nxt = bdata;
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  // FIFO storage; only occupied entries are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bdata;
    end
  end

  // FIFO pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= {PW{1'b0}};
      r_rptr      <= {PW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_out_valid <= 1'b0;
      r_out_data  <= {WIDTH{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != {CW{1'b0}});
      r_out_data  <= w_head_nxt;
    end
  end

  assign back      = r_back;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign count     = r_count;

endmodule

// File: tb/tb_bd_sync_receiver.sv
// Directed self-checking bench for bd_sync_receiver (WIDTH=8, SYNC_STAGES=2, DEPTH=4).
module tb_bd_sync_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       breq;
  logic       back;
  logic [7:0] bdata;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] pops [$];

  bd_sync_receiver #(
    .WIDTH       (8),
    .SYNC_STAGES (2),
    .DEPTH       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .breq      (breq),
    .back      (back),
    .bdata     (bdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Record every accepted head word.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) pops.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_back(input logic val, input string tag);
    int n = 0;
    while (back !== val && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(back), 32'(val));
  endtask

  task automatic send_token(input logic [7:0] d);
    breq  = 1'b1;
    bdata = d;
    wait_back(1'b1, "send_ack_rise");
    breq = 1'b0;
    wait_back(1'b0, "send_ack_fall");
  endtask

  initial begin
    rst = 1'b1; breq = 1'b0; bdata = 8'h00; out_ready = 1'b0;
    tick(); tick();
    check("rst_back", 32'(back), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick();

    // Single token latency
    breq = 1'b1; bdata = 8'hA5; out_ready = 1'b1;
    tick(); check("t1_back_e0", 32'(back), 32'd0);
    tick(); check("t1_back_e1", 32'(back), 32'd0);
    check("t1_valid_e1", 32'(out_valid), 32'd0);
    tick(); check("t1_back_e2", 32'(back), 32'd1);
    check("t1_valid_e2", 32'(out_valid), 32'd1);
    check("t1_data_e2", 32'(out_data), 32'hA5);
    check("t1_count_e2", 32'(count), 32'd1);
    tick(); check("t1_count_e3", 32'(count), 32'd0);
    check("t1_valid_e3", 32'(out_valid), 32'd0);
    check("t1_hold_data", 32'(out_data), 32'hA5);
    breq = 1'b0;
    tick(); check("t1_back_d1", 32'(back), 32'd1);
    tick(); check("t1_back_d2", 32'(back), 32'd1);
    tick(); check("t1_back_d3", 32'(back), 32'd0);

    // Back-to-back tokens with pointer wrap
    pops.delete();
    for (int i = 1; i <= 8; i++) send_token(8'(i));
    tick(); tick();
    check("t2_npops", 32'(pops.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < pops.size()) check("t2_order", 32'(pops[i]), 32'(i + 1));
    end
    check("t2_count", 32'(count), 32'd0);

    // Full backpressure
    out_ready = 1'b0;
    pops.delete();
    for (int i = 1; i <= 4; i++) send_token(8'(i));
    check("t3_count_full", 32'(count), 32'd4);
    check("t3_head", 32'(out_data), 32'h01);
    breq = 1'b1; bdata = 8'h05;
    for (int i = 0; i < 6; i++) tick();
    check("t3_back_stall", 32'(back), 32'd0);
    check("t3_count_stall", 32'(count), 32'd4);
    out_ready = 1'b1;
    tick();
    check("t3_count_pop", 32'(count), 32'd3);
    check("t3_back_pop", 32'(back), 32'd0);
    check("t3_head_pop", 32'(out_data), 32'h02);
    out_ready = 1'b0;
    tick();
    check("t3_count_push", 32'(count), 32'd4);
    check("t3_back_push", 32'(back), 32'd1);
    breq = 1'b0;
    wait_back(1'b0, "t3_back_fall");

    // Simultaneous push and pop at count 2
    out_ready = 1'b1;
    tick(); tick();
    check("t4_count_pre", 32'(count), 32'd2);
    out_ready = 1'b0;
    breq = 1'b1; bdata = 8'h06;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    check("t4_count_same", 32'(count), 32'd2);
    check("t4_head", 32'(out_data), 32'h05);
    check("t4_back", 32'(back), 32'd1);
    out_ready = 1'b0;
    breq = 1'b0;
    wait_back(1'b0, "t4_back_fall");
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    check("t4_count_end", 32'(count), 32'd0);
    check("t4_last_data", 32'(out_data), 32'h06);
    check("t4_npops", 32'(pops.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < pops.size()) check("t4_order", 32'(pops[i]), 32'(i + 1));
    end

    // Reset in the middle of a handshake
    send_token(8'h31);
    send_token(8'h32);
    breq = 1'b1; bdata = 8'h33;
    wait_back(1'b1, "t5_ack");
    check("t5_count_pre", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    check("t5_back_rst", 32'(back), 32'd0);
    check("t5_count_rst", 32'(count), 32'd0);
    check("t5_valid_rst", 32'(out_valid), 32'd0);
    check("t5_data_rst", 32'(out_data), 32'd0);
    rst = 1'b0;
    wait_back(1'b1, "t5_recapture");
    check("t5_count_new", 32'(count), 32'd1);
    check("t5_data_new", 32'(out_data), 32'h33);
    breq = 1'b0;
    wait_back(1'b0, "t5_back_fall");
    for (int i = 0; i < 4; i++) tick();
    check("t5_one_token", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    check("t5_drain", 32'(count), 32'd0);

    // Idle stability
    for (int i = 0; i < 50; i++) begin
      out_ready = i[0];
      tick();
      check("t6_back", 32'(back), 32'd0);
      check("t6_count", 32'(count), 32'd0);
      check("t6_valid", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bd_sync_receiver.md
Name: bd_sync_receiver

Overview:
Clocked receiving end of the 4-phase bundled-data channel. It accepts tokens from an asynchronous BD stage (breq/back/bdata), synchronizes the request into the clock domain, and captures the data into a small FIFO. It presents the tokens to synchronous logic through a valid/ready interface. It sits at the boundary where the asynchronous spiking datapath hands results to clocked NoC/control logic.

Parameters:
WIDTH, 8, data width of the bundled-data channel and the FIFO entries
SYNC_STAGES, 2, number of flip-flops synchronizing breq (minimum 2)
DEPTH, 4, FIFO entries (power of 2, minimum 2)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
breq  input  1  BD request from the asynchronous sender (4-phase)
back  output  1  BD acknowledge to the sender; registered
bdata  input  WIDTH  bundled data; stable from breq rise until back rise
out_valid  output  1  FIFO head is valid
out_ready  input  1  consumer accepts the head this cycle
out_data  output  WIDTH  FIFO head, first-word fall-through
count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at an edge): back=0, out_valid=0, count=0, out_data=0, FIFO pointers=0, synchronizer flops=0, state=IDLE. Reset has priority over every other event.
- req_s is the last synchronizer stage. No logic reads breq or bdata except the synchronizer and the capture path.
- FSM is bd_rx_state_t with states IDLE, ACKED.
  - IDLE: if req_s=1 and count<DEPTH, then push bdata, back<=1, go to ACKED. If req_s=1 and the FIFO is full, stay in IDLE with back=0; this is backpressure, and the sender stalls.
  - ACKED: back stays 1 until req_s=0, then back<=0 and the FSM returns to IDLE (return-to-zero phase complete).
- Bundled-data timing: bdata is sampled at the same edge that sees req_s=1. It is guaranteed stable because the sender holds data from breq rise until it observes back.
- Latency: with breq rising before edge 0, req_s=1 after edge SYNC_STAGES-1. Capture and back=1 happen at edge SYNC_STAGES, and out_valid=1 from that same edge (fall-through). back falls SYNC_STAGES+1 edges after breq falls.
- Throughput: at most one token per 2*(SYNC_STAGES+1) cycles plus the sender's delay.
- FIFO:
  - Pop when out_valid && out_ready.
  - The push decision uses the registered count, so a pop in the same cycle as a full-FIFO request does not enable a push in that cycle. The push happens on the next edge.
  - Simultaneous push and pop when not full: count is unchanged, and both pointers advance modulo DEPTH.
  - Pointers wrap at DEPTH. out_data holds the head value and never shows X. When empty, out_data holds the last value.
  - out_ready while empty has no effect.
- Reset mid-handshake: state returns to IDLE and back=0. If breq is still high after reset, it is captured as a new token; the sender must be reset in the same cycle.
- Exactly one push per breq pulse. No push is allowed in ACKED.

Decomposition:
- Package bd_pkg: typedef enum logic [0:0] bd_rx_state_t {IDLE, ACKED}; localparam BD_MIN_SYNC=2.
- Sub-module bd_req_sync: SYNC_STAGES-deep flop chain with synchronous reset, one instance for breq.
- The FIFO stays inline.

Test Plan:
- Single token: breq=1 with bdata=8'hA5, out_ready=1 -> back=1 and out_valid=1 with out_data=8'hA5 at edge 2. After breq drops, back=0 at edge 3 after the drop. count returns to 0.
- Back-to-back 8 tokens 8'h01..8'h08 with out_ready=1 -> out_data sequence 01..08 in order, exactly 8 pops, no duplicates. The read and write pointers wrap twice.
- Full backpressure: out_ready=0, send 5 tokens with DEPTH=4 -> count=4 and back stays 0 on the 5th request. Raise out_ready for 1 cycle -> pop 8'h01, then the 5th token is captured one edge later and count=4.
- Simultaneous push and pop at count=2 -> count stays 2 and data order is preserved.
- Reset mid-handshake: rst=1 while in ACKED with count=3 -> after the edge, back=0, count=0, out_valid=0. breq held high -> re-captured as one token.
- Idle stability: breq=0 for 50 cycles with out_ready toggling -> back=0, count=0, out_valid=0 throughout.
